sobel_scan_ctrl: RTL and testbench



---
 rtl/sobel_scan_ctrl.sv | 96 +++++++++
 tb/tb_sobel_scan_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sobel_scan_ctrl.sv
// Frame sequencer for the 3x3 line-buffered filter: raster-scans one frame on START,
// paces the filter against the source/destination FIFO flags and counts delayed filter writes.
module sobel_scan_ctrl #(
  parameter int H_SIZE   = 1920,
  parameter int V_SIZE   = 1080,
  parameter int FILT_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SRC_EMPTY,
  output logic        SRC_RDEN,
  input  logic        DST_AFULL,
  output logic        READY,
  output logic [11:0] POSX,
  output logic [11:0] POSY,
  input  logic        FILT_WREN,
  output logic        DST_WREN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  dbg_state
);

  localparam logic [23:0] TOTAL  = 24'(H_SIZE * V_SIZE);
  localparam logic [11:0] X_LAST = 12'(H_SIZE - 1);
  localparam logic [11:0] Y_LAST = 12'(V_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t      state, state_nxt;
  logic [23:0] wcnt, wcnt_nxt;
  logic        ready, last_px, count_en, err_set, start_acc;

  // Handshake: READY is the only advance strobe; one pixel moves per high cycle,
  // and it responds combinationally to SRC_EMPTY/DST_AFULL in the same cycle.
  always_comb begin
    ready     = (state == S_RUN) && !SRC_EMPTY && !DST_AFULL;
    last_px   = ready && (POSX == X_LAST) && (POSY == Y_LAST);
    start_acc = (state == S_IDLE) && START;
    count_en  = FILT_WREN && (state != S_IDLE);
    err_set   = count_en && (wcnt == TOTAL);
    wcnt_nxt  = wcnt;
    if (count_en && (wcnt != TOTAL)) wcnt_nxt = wcnt + 24'd1;
  end

  // Completion looks at the count including this cycle's write, so DONE lands
  // exactly one cycle after the final filter write.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_RUN;
      S_RUN:   if (last_px) state_nxt = (wcnt_nxt == TOTAL) ? S_FIN : S_DRAIN;
      S_DRAIN: if (wcnt_nxt == TOTAL) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      POSX  <= '0;
      POSY  <= '0;
      wcnt  <= '0;
      ERR   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        POSX <= '0;
        POSY <= '0;
        wcnt <= '0;
        ERR  <= 1'b0;
      end else begin
        wcnt <= wcnt_nxt;
        if (err_set) ERR <= 1'b1;
        if (ready) begin
          if (POSX == X_LAST) begin
            POSX <= '0;
            POSY <= (POSY == Y_LAST) ? 12'd0 : POSY + 12'd1;
          end else begin
            POSX <= POSX + 12'd1;
          end
        end
      end
    end
  end

  assign READY     = ready;
  assign SRC_RDEN  = ready;
  assign DST_WREN  = FILT_WREN;
  assign BUSY      = (state == S_RUN) || (state == S_DRAIN);
  assign DONE      = (state == S_FIN);
  assign dbg_state = state;

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Bench for sobel_scan_ctrl on a 4x3 frame: randomized FIFO flags, a latency-2 filter
// model, and a frame-level reference model (beat/write counts) checked every cycle.
module tb_sobel_scan_ctrl;

  localparam int H = 4;
  localparam int V = 3;
  localparam int L = 2;
  localparam int TOTAL = H * V;

  logic        CLK, RST, START, SRC_EMPTY, DST_AFULL, FILT_WREN;
  logic        SRC_RDEN, READY, DST_WREN, BUSY, DONE, ERR;
  logic [11:0] POSX, POSY;
  logic [1:0]  dbg_state;

  sobel_scan_ctrl #(.H_SIZE(H), .V_SIZE(V), .FILT_LAT(L)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SRC_EMPTY(SRC_EMPTY), .SRC_RDEN(SRC_RDEN),
    .DST_AFULL(DST_AFULL), .READY(READY), .POSX(POSX), .POSY(POSY),
    .FILT_WREN(FILT_WREN), .DST_WREN(DST_WREN), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // reference model: frame progress in pixels consumed and writes counted
  bit m_active, m_fin, m_err;
  int m_beats, m_writes;
  logic [L-1:0] pipe;          // filter model: READY delayed by L cycles
  int seen_ready, seen_done;

  task automatic cycle(input bit st, input bit rs, input bit em, input bit af, input bit ex);
    bit exp_ready;
    int p;
    @(posedge CLK);
    #1;
    START = st; RST = rs; SRC_EMPTY = em; DST_AFULL = af;
    FILT_WREN = pipe[L-1] | ex;
    @(negedge CLK);
    exp_ready = m_active && !m_fin && (m_beats < TOTAL) && !em && !af;
    p = m_beats % TOTAL;
    check("ready",    32'(READY),    32'(exp_ready));
    check("src_rden", 32'(SRC_RDEN), 32'(exp_ready));
    check("posx",     32'(POSX),     32'(p % H));
    check("posy",     32'(POSY),     32'(p / H));
    check("busy",     32'(BUSY),     32'(m_active && !m_fin));
    check("done",     32'(DONE),     32'(m_fin));
    check("err",      32'(ERR),      32'(m_err));
    check("dst_wren", 32'(DST_WREN), 32'(FILT_WREN));
    if (READY) seen_ready++;
    if (DONE)  seen_done++;
    if (rs) begin
      m_active = 0; m_fin = 0; m_err = 0; m_beats = 0; m_writes = 0; pipe = '0;
    end else begin
      if (m_active && FILT_WREN) begin
        if (m_writes == TOTAL) m_err = 1;
        else m_writes++;
      end
      if (m_fin) begin
        m_active = 0; m_fin = 0;
      end else if (m_active) begin
        if (exp_ready) m_beats++;
        if (m_beats == TOTAL && m_writes == TOTAL) m_fin = 1;
      end else if (st) begin
        m_active = 1; m_beats = 0; m_writes = 0; m_err = 0;
      end
      pipe = {pipe[L-2:0], READY};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // mode: 0 free run, 1 empty toggling, 2 random stalls, 3 AFULL x5 at (2,1),
  //       4 second START at pixel 5, 5 RST at pixel 7, 6 extra write in FIN
  task automatic run_frame(input int mode);
    int budget, af_left, t;
    bit em, af, st, rs, ex, af_done, rs_done;
    seen_ready = 0; seen_done = 0; af_left = 0; af_done = 0; rs_done = 0; t = 0;
    cycle(1, 0, 0, 0, 0);
    budget = 300;
    while (m_active && budget > 0) begin
      em = 0; af = 0; st = 0; rs = 0; ex = 0;
      case (mode)
        1: em = t[0];
        2: begin
          em = ($urandom_range(0, 3) == 0);
          af = ($urandom_range(0, 4) == 0);
        end
        3: begin
          if (!af_done && m_beats == 6) begin af_left = 5; af_done = 1; end
          if (af_left > 0) begin af = 1; af_left--; end
        end
        4: st = (m_beats == 5);
        5: if (!rs_done && m_beats == 7) begin rs = 1; rs_done = 1; end
        6: ex = m_fin;
        default: ;
      endcase
      cycle(st, rs, em, af, ex);
      budget--; t++;
    end
    check("frame_timeout", 32'(budget == 0), 32'd0);
    if (mode != 5) begin
      check("ready_beats", 32'(seen_ready), 32'(TOTAL));
      check("done_pulses", 32'(seen_done), 32'd1);
    end
  endtask

  initial begin
    START = 0; SRC_EMPTY = 0; DST_AFULL = 0; FILT_WREN = 0; RST = 1;
    m_active = 0; m_fin = 0; m_err = 0; m_beats = 0; m_writes = 0; pipe = '0;
    repeat (2) @(posedge CLK);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 1);
    cycle(0, 0, 0, 0, 0);
    idle(3);
    run_frame(0);
    idle(2);
    run_frame(1);
    idle(2);
    run_frame(3);
    idle(2);
    run_frame(4);
    idle(1);
    run_frame(5);
    idle(3);
    run_frame(0);
    idle(2);
    run_frame(6);
    idle(5);
    check("err_sticky", 32'(ERR), 32'd1);
    run_frame(0);
    for (int k = 0; k < 6; k++) begin
      idle($urandom_range(1, 4));
      run_frame(2);
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
